stack_param: RTL and testbench

STACK_PARAM -- requirements
Module: stack_param

---
 rtl/stack_param.sv | 103 ++++++++++
 tb/tb_stack_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_param.sv
// rtl/stack_param.sv - parameterised LIFO stack with registered overflow/underflow pulses and sticky error
// Defining STACK_PARAM_ERR_CNT_EN adds a saturating 8-bit err_count output.
module stack_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      err_clr,
  input  logic [DATA_WIDTH-1:0]     write_data,
  output logic [DATA_WIDTH-1:0]     read_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      error
`ifdef STACK_PARAM_ERR_CNT_EN
  ,
  output logic [7:0]                err_count
`endif
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] IDX_ONE  = PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_idx;
  logic [PTR_WIDTH-1:0]  top_idx;
  logic                  do_push;
  logic                  do_pop;
  logic                  do_replace;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic                  err_evt;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign wr_idx  = count[PTR_WIDTH-1:0];
  // When full the low bits wrap to zero, so subtracting one still lands on the top slot.
  assign top_idx = wr_idx - IDX_ONE;

  assign do_replace = push && pop && !empty;
  // Push+pop on an empty stack falls through here as a plain push.
  assign do_push    = push && !full && !do_replace;
  assign do_pop     = pop && !push && !empty;
  assign ovf_evt    = push && !pop && full;
  assign unf_evt    = pop && empty;
  assign err_evt    = ovf_evt || unf_evt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_replace) begin
        mem[top_idx] <= write_data;
      end else if (do_push) begin
        mem[wr_idx] <= write_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      read_data <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (do_push) begin
        count <= count + CNT_ONE;
      end else if (do_pop) begin
        count <= count - CNT_ONE;
      end
      if (do_pop || do_replace) begin
        read_data <= mem[top_idx];
      end
      overflow  <= ovf_evt;
      underflow <= unf_evt;
      error     <= err_evt || (error && !err_clr);
    end
  end

`ifdef STACK_PARAM_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_evt) begin
      if (err_clr) begin
        err_count <= 8'd1;
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end else if (err_clr) begin
      err_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_stack_param.sv
// tb/tb_stack_param.sv - self-checking bench for stack_param against a queue-based LIFO model
module tb_stack_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic          pop;
  logic          err_clr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic [2:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic          error;
`ifdef STACK_PARAM_ERR_CNT_EN
  logic [7:0]    err_count;
`endif

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic          m_ovf;
  logic          m_unf;
  logic          m_err;
  int            m_ecnt;

  always #5 clk = ~clk;

  stack_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .err_clr    (err_clr),
    .write_data (write_data),
    .read_data  (read_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow),
    .error      (error)
`ifdef STACK_PARAM_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd   = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_err  = 1'b0;
    m_ecnt = 0;
  endtask

  task automatic model_op(input logic p, input logic po, input logic clr, input logic [DW-1:0] wd);
    logic evt;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (p && po) begin
      if (q.size() == 0) begin
        q.push_back(wd);
        m_unf = 1'b1;
      end else begin
        m_rd = q[q.size()-1];
        q[q.size()-1] = wd;
      end
    end else if (p) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(wd);
    end else if (po) begin
      if (q.size() == 0) m_unf = 1'b1;
      else m_rd = q.pop_back();
    end
    evt   = m_ovf | m_unf;
    m_err = evt | (m_err & ~clr);
    if (evt) m_ecnt = clr ? 1 : ((m_ecnt < 255) ? m_ecnt + 1 : 255);
    else if (clr) m_ecnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".read_data"}, 32'(read_data), 32'(m_rd));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".error"},     32'(error),     32'(m_err));
`ifdef STACK_PARAM_ERR_CNT_EN
    chk({tag, ".err_count"}, 32'(err_count), 32'(m_ecnt));
`endif
  endtask

  // Called at a negedge: drive, clock once, update model, sample at the next negedge.
  task automatic step(input string tag, input logic p, input logic po, input logic clr,
                      input logic [DW-1:0] wd);
    push = p; pop = po; err_clr = clr; write_data = wd;
    @(posedge clk);
    model_op(p, po, clr, wd);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; write_data = '0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 1; i <= 4; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0, DW'(i));
    chk("fill.full_const", 32'(full), 32'd1);

    step("ovf", 1'b1, 1'b0, 1'b0, 8'h05);
    chk("ovf.pulse_const", 32'(overflow), 32'd1);
    chk("ovf.count_const", 32'(count), 32'd4);
    step("ovf_idle", 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 4; i >= 1; i--) begin
      step($sformatf("drain%0d", i), 1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("drain%0d.rd_const", i), 32'(read_data), 32'(i));
    end
    chk("drain.empty_const", 32'(empty), 32'd1);

    step("unf", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("unf.rd_held", 32'(read_data), 32'h01);
    step("clr", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr.error_const", 32'(error), 32'd0);

    step("pp_empty", 1'b1, 1'b1, 1'b0, 8'h0A);
    step("push_b", 1'b1, 1'b0, 1'b0, 8'h0B);
    step("replace", 1'b1, 1'b1, 1'b0, 8'h0C);
    chk("replace.rd_const", 32'(read_data), 32'h0B);
    step("pop_c", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("pop_c.rd_const", 32'(read_data), 32'h0C);
    step("pop_a", 1'b0, 1'b1, 1'b0, 8'h00);
    step("clr2", 1'b0, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 4; i++) step($sformatf("fillr%0d", i), 1'b1, 1'b0, 1'b0, DW'($urandom));
    step("replace_full", 1'b1, 1'b1, 1'b0, 8'hE7);
    step("clr3", 1'b0, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i),
           $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 10, DW'($urandom));
    end

    while (q.size() > 0) step("pre_rst_drain", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step($sformatf("pre_rst%0d", i), 1'b1, 1'b0, 1'b0, DW'(8'h20 + i));
    step("pre_rst_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    step("pre_rst_push", 1'b1, 1'b0, 1'b0, 8'h33);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.read_data", 32'(read_data), 32'd0);
    chk("async_rst.empty", 32'(empty), 32'd1);
    @(negedge clk);
    push = 1'b1; pop = 1'b0; write_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    push = 1'b0;
    check_all("rst_held_push");
    rst = 1'b0;
    step("post_rst_push", 1'b1, 1'b0, 1'b0, 8'h55);
    step("post_rst_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_rst_pop.rd_const", 32'(read_data), 32'h55);

`ifdef STACK_PARAM_ERR_CNT_EN
    for (int i = 0; i < 300; i++) step("sat_pop", 1'b0, 1'b1, 1'b0, 8'h00);
    chk("sat.err_count_const", 32'(err_count), 32'd255);
    step("sat_clr_evt", 1'b0, 1'b1, 1'b1, 8'h00);
    step("sat_clr", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("sat_clr.err_count_const", 32'(err_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
